// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module  : clk_div_pkg
// Brief   : Shared types and helpers for the clock divider bank.
// Revision: 1.0 - initial release
// ============================================================================
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        STOP_PEND = 2'd2
    } ch_state_t;

    // Widest divisor field for which the default-divisor helper stays exact.
    localparam int DEF_DIV_MAX_W = 31;

    // Largest divisor that fits in a field of the given width.
    function automatic int def_div_max(input int div_w);
        return (div_w >= DEF_DIV_MAX_W) ? 32'h7fff_ffff : ((1 << div_w) - 1);
    endfunction

    // Channel-select width; never narrower than one bit.
    function automatic int ch_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// ============================================================================
// Module  : clk_div_chan
// Brief   : One divider channel: run/stop FSM, phase counter, divisor staging.
// Revision: 1.0 - initial release
// ============================================================================
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DIV_W   = 8,
    parameter int DEF_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             wr_en,
    input  logic [DIV_W-1:0] wr_div,
    output logic             clk_out,
    output logic             tick,
    output logic             running
);

    localparam logic [DIV_W-1:0] c_DEF_DIV = DIV_W'(DEF_DIV);

    ch_state_t        r_state,   w_state_nxt;
    logic [DIV_W-1:0] r_cnt,     w_cnt_nxt;
    logic [DIV_W-1:0] r_active,  w_active_nxt;
    logic [DIV_W-1:0] r_pending, w_pending_nxt;
    logic             r_clk,     w_clk_nxt;
    logic             r_tick;
    logic             w_wrap;

    always_comb begin
        w_wrap        = (r_cnt == r_active);
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_clk_nxt     = r_clk;
        w_active_nxt  = r_active;
        w_pending_nxt = wr_en ? wr_div : r_pending;

        case (r_state)
            IDLE: begin
                w_cnt_nxt    = '0;
                w_clk_nxt    = 1'b0;
                w_active_nxt = w_pending_nxt;
                if (enable) begin
                    w_state_nxt = RUN;
                end
            end
            RUN, STOP_PEND: begin
                if (r_state == RUN && !enable && !r_clk) begin
                    // Low phase: stop immediately, nothing to finish.
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    // Wrap uses the divisor in force now; a same-cycle write
                    // only lands in pending and waits for the next boundary.
                    if (w_wrap) begin
                        w_cnt_nxt    = '0;
                        w_clk_nxt    = ~r_clk;
                        w_active_nxt = r_pending;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                    if (enable) begin
                        w_state_nxt = RUN;
                    end else if (w_wrap && r_clk) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = STOP_PEND;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_clk_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_active  <= c_DEF_DIV;
            r_pending <= c_DEF_DIV;
            r_clk     <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_active  <= w_active_nxt;
            r_pending <= w_pending_nxt;
            r_clk     <= w_clk_nxt;
            r_tick    <= w_clk_nxt & ~r_clk;
        end
    end

    assign clk_out = r_clk;
    assign tick    = r_tick;
    assign running = (r_state != IDLE);

endmodule
`default_nettype wire

// File: rtl/clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module  : clk_div_bank
// Brief   : NCH independently enabled, runtime-programmable clock dividers.
// Revision: 1.0 - initial release
// ============================================================================
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter  int NCH     = 3,
    parameter  int DIV_W   = 8,
    parameter  int DEF_DIV = 4,
    localparam int CH_W    = ch_w(NCH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   ch_enable,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_chan,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_err,
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   running
);

    logic        r_ready;
    logic        r_err;
    logic        w_wr;
    logic        w_bad_chan;
    logic [31:0] w_chan_ext;

    assign w_wr       = cfg_valid & r_ready;
    assign w_chan_ext = 32'(cfg_chan);
    assign w_bad_chan = (w_chan_ext >= 32'(NCH));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ready <= 1'b1;
            r_err   <= w_wr & w_bad_chan;
        end
    end

    assign cfg_ready = r_ready;
    assign cfg_err   = r_err;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        logic w_wr_en;
        assign w_wr_en = w_wr & ~w_bad_chan & (cfg_chan == CH_W'(i));

        clk_div_chan #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .enable  (ch_enable[i]),
            .wr_en   (w_wr_en),
            .wr_div  (cfg_div),
            .clk_out (clk_out[i]),
            .tick    (tick[i]),
            .running (running[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module  : tb_clk_div_bank
// Brief   : Self-checking bench for clk_div_bank against a phase-length model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_clk_div_bank;

    localparam int NCH     = 3;
    localparam int DIV_W   = 8;
    localparam int DEF_DIV = 4;
    localparam int CH_W    = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [NCH-1:0]   ch_enable;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_chan;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_err;
    logic [NCH-1:0]   clk_out;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   running;

    int checks = 0;
    int errors = 0;

    // Reference: each channel is a level plus the number of cycles left in
    // the current phase; a phase of divisor D lasts D+1 cycles.
    bit m_run  [NCH];
    bit m_lvl  [NCH];
    bit m_tick [NCH];
    int m_left [NCH];
    int m_act  [NCH];
    int m_pend [NCH];
    bit m_ready;
    bit m_err;

    always #5 clk = ~clk;

    clk_div_bank #(
        .NCH     (NCH),
        .DIV_W   (DIV_W),
        .DEF_DIV (DEF_DIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ch_enable (ch_enable),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_div   (cfg_div),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .tick      (tick),
        .running   (running)
    );

    task automatic model_edge();
        bit acc;
        bit chan_ok;
        acc     = cfg_valid && m_ready;
        chan_ok = (int'(cfg_chan) < NCH);
        if (!reset) begin
            m_ready = 1'b0;
            m_err   = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                m_run[i]  = 1'b0;
                m_lvl[i]  = 1'b0;
                m_tick[i] = 1'b0;
                m_left[i] = 0;
                m_act[i]  = DEF_DIV;
                m_pend[i] = DEF_DIV;
            end
            return;
        end
        m_err   = acc && !chan_ok;
        m_ready = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            bit wr;
            wr        = acc && chan_ok && (int'(cfg_chan) == i);
            m_tick[i] = 1'b0;
            if (!m_run[i]) begin
                if (wr) m_pend[i] = int'(cfg_div);
                m_act[i] = m_pend[i];
                if (ch_enable[i]) begin
                    m_run[i]  = 1'b1;
                    m_left[i] = m_act[i] + 1;
                end
            end else if (!ch_enable[i] && !m_lvl[i]) begin
                m_run[i] = 1'b0;
                if (wr) m_pend[i] = int'(cfg_div);
            end else begin
                m_left[i] = m_left[i] - 1;
                if (m_left[i] == 0) begin
                    m_lvl[i]  = !m_lvl[i];
                    m_tick[i] = m_lvl[i];
                    m_act[i]  = m_pend[i];
                    m_left[i] = m_act[i] + 1;
                    if (!ch_enable[i] && !m_lvl[i]) m_run[i] = 1'b0;
                end
                if (wr) m_pend[i] = int'(cfg_div);
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NCH; i++) begin
            checks++;
            assert (clk_out[i] === m_lvl[i]) else begin
                errors++;
                $error("FAIL clk_out[%0d]: observed %b expected %b", i, clk_out[i], m_lvl[i]);
            end
            checks++;
            assert (tick[i] === m_tick[i]) else begin
                errors++;
                $error("FAIL tick[%0d]: observed %b expected %b", i, tick[i], m_tick[i]);
            end
            checks++;
            assert (running[i] === m_run[i]) else begin
                errors++;
                $error("FAIL running[%0d]: observed %b expected %b", i, running[i], m_run[i]);
            end
        end
        checks++;
        assert (cfg_ready === m_ready) else begin
            errors++;
            $error("FAIL cfg_ready: observed %b expected %b", cfg_ready, m_ready);
        end
        checks++;
        assert (cfg_err === m_err) else begin
            errors++;
            $error("FAIL cfg_err: observed %b expected %b", cfg_err, m_err);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Advance until the model's channel level equals v; returns cycles taken.
    task automatic wait_lvl(input int ch, input bit v, input string tag, output int n);
        n = 0;
        while (m_lvl[ch] != v && n < 64) begin
            step();
            n++;
        end
        checks++;
        assert (m_lvl[ch] == v) else begin
            errors++;
            $error("FAIL %s: timeout, observed level %b expected %b", tag, m_lvl[ch], v);
        end
    endtask

    initial begin
        int n;
        reset     = 1'b0;
        ch_enable = '0;
        cfg_valid = 1'b0;
        cfg_chan  = '0;
        cfg_div   = '0;
        steps(3);
        reset = 1'b1;
        step();

        // First edge D+1 cycles after the first RUN cycle, then a 10-cycle period.
        ch_enable = 3'b001;
        step();
        wait_lvl(0, 1'b1, "first_rise", n);
        checks++;
        assert (n == 5) else begin
            errors++;
            $error("FAIL first_rise_delay: observed %0d expected %0d", n, 5);
        end
        wait_lvl(0, 1'b0, "fall", n);
        wait_lvl(0, 1'b1, "second_rise", n);
        steps(1);
        wait_lvl(0, 1'b0, "fall2", n);
        wait_lvl(0, 1'b1, "third_rise", n);
        checks++;
        assert (n == 5) else begin
            errors++;
            $error("FAIL low_phase_len: observed %0d expected %0d", n, 5);
        end

        // Divisor write mid high phase takes effect at the next boundary.
        step();
        cfg_valid = 1'b1; cfg_chan = 2'd0; cfg_div = 8'd1;
        step();
        cfg_valid = 1'b0;
        steps(20);

        // Stop during high phase, then during low phase.
        wait_lvl(0, 1'b1, "hi_for_stop", n);
        step();
        ch_enable = 3'b000;
        steps(8);
        ch_enable = 3'b001;
        wait_lvl(0, 1'b1, "hi_again", n);
        wait_lvl(0, 1'b0, "lo_for_stop", n);
        ch_enable = 3'b000;
        steps(4);

        // Re-enable while a stop is pending.
        cfg_valid = 1'b1; cfg_chan = 2'd0; cfg_div = 8'd4;
        ch_enable = 3'b001;
        step();
        cfg_valid = 1'b0;
        wait_lvl(0, 1'b1, "hi_for_reen", n);
        step();
        ch_enable = 3'b000;
        step();
        ch_enable = 3'b001;
        steps(25);

        // Out-of-range channel write.
        cfg_valid = 1'b1; cfg_chan = 2'd3; cfg_div = 8'd0;
        step();
        cfg_valid = 1'b0;
        steps(12);

        // All channels running with distinct divisors, then reset mid high phase.
        cfg_valid = 1'b1; cfg_chan = 2'd1; cfg_div = 8'd0;
        step();
        cfg_chan = 2'd2; cfg_div = 8'd2;
        step();
        cfg_valid = 1'b0;
        ch_enable = 3'b111;
        steps(20);
        wait_lvl(0, 1'b1, "hi_for_reset", n);
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        ch_enable = 3'b000;
        steps(2);
        ch_enable = 3'b111;
        steps(30);

        // Randomized traffic.
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 9) == 0) begin
                int k;
                k = int'($urandom_range(0, NCH - 1));
                ch_enable[k] = ~ch_enable[k];
            end
            cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_chan  = CH_W'($urandom_range(0, 3));
            cfg_div   = DIV_W'($urandom_range(0, 5));
            reset     = ($urandom_range(0, 299) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
